data_mem_responder: RTL and testbench

- Memory-side responder for CPU load/store requests. It replaces the zero-wait combinational data memory whenever the core is driven through a request/response handshake.
- Accepts one word-aligned read or write at a time and inserts a programmable number of wait states. It returns a single response carrying read data or an error flag.
- Serves as the target end of the data-memory interface used by the multi-cycle and pipelined cores.

---
 rtl/mem_if_pkg.sv | 22 ++
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/mem_array_sp.sv | 37 +++
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory request/response interface.
// Both the responder and the cores' request-side adapter import this package.
package mem_if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BE_WIDTH   = WORD_BYTES;

    // 33-bit offset so that a window ending at 2^32 does not wrap.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [32:0] span);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr[1:0] != 2'b00) || (addr < base) || (off >= span);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between a core (master) and the data memory (slave).
interface data_mem_responder_if;
    import mem_if_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [31:0]         req_addr;
    logic [31:0]         req_wdata;
    logic [BE_WIDTH-1:0] req_be;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_rdata;
    logic                resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_array_sp.sv
// Single-port byte-enabled synchronous RAM; one access per enabled edge.
// A load registers the addressed word; a store writes only the enabled bytes.
module mem_array_sp
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [31:0]         wdata_i,
    input  logic [BE_WIDTH-1:0] be_i,
    output logic [31:0]         rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target: accepts one word access at a time, waits LATENCY cycles,
// commits to the RAM on the edge entering RESP and holds the response until taken.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SpanBytes = 33'(WORD_BYTES * DEPTH_WORDS);
    localparam logic [3:0]  LatInit   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [BE_WIDTH-1:0] be_q, be_d;
    logic                err_q, err_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic                resp_load_q, resp_load_d;

    logic                req_err;
    logic [IdxW-1:0]     req_idx;
    logic                commit;
    logic                commit_err;
    logic                ram_en;
    logic                ram_we;
    logic [IdxW-1:0]     ram_idx;
    logic [31:0]         ram_wdata;
    logic [BE_WIDTH-1:0] ram_be;
    logic [31:0]         ram_rdata;

    assign req_err = addr_err(bus.req_addr, BASE_ADDR, SpanBytes);
    assign req_idx = IdxW'((bus.req_addr - BASE_ADDR) >> 2);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        err_d        = err_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_load_d  = resp_load_q;
        commit       = 1'b0;
        commit_err   = err_q;
        ram_we       = write_q;
        ram_idx      = idx_q;
        ram_wdata    = wdata_q;
        ram_be       = be_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d     = bus.req_write;
                    idx_d       = req_idx;
                    wdata_d     = bus.req_wdata;
                    be_d        = bus.req_be;
                    err_d       = req_err;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        // Zero wait states: commit straight from the request inputs.
                        state_d    = S_RESP;
                        commit     = 1'b1;
                        commit_err = req_err;
                        ram_we     = bus.req_write;
                        ram_idx    = req_idx;
                        ram_wdata  = bus.req_wdata;
                        ram_be     = bus.req_be;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LatInit;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = S_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_load_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            resp_valid_d = 1'b1;
            resp_err_d   = commit_err;
            resp_load_d  = !ram_we && !commit_err;
        end
        ram_en = commit && !commit_err && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_load_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_load_q  <= resp_load_d;
        end
    end

    mem_array_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IdxW)
    ) u_mem (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (ram_wdata),
        .be_i    (ram_be),
        .rdata_o (ram_rdata)
    );

    // RAM output is only meaningful for a successful load; everything else reads as zero.
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_load_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance share one
// stimulus driver (selected by sel) and are checked against a word-array model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk;
    logic reset;
    logic sel;
    logic tb_req_valid, tb_write, tb_resp_ready;
    logic [31:0] tb_addr, tb_wdata;
    logic [3:0] tb_be;

    logic obs_req_ready, obs_resp_valid, obs_resp_err;
    logic [31:0] obs_resp_rdata;

    int checks;
    int errors;

    logic [31:0] model_mem [2][DEPTH];

    data_mem_responder_if if2 ();
    data_mem_responder_if if0 ();

    assign if2.req_valid  = tb_req_valid && !sel;
    assign if0.req_valid  = tb_req_valid && sel;
    assign if2.resp_ready = tb_resp_ready && !sel;
    assign if0.resp_ready = tb_resp_ready && sel;
    assign if2.req_write  = tb_write;
    assign if0.req_write  = tb_write;
    assign if2.req_addr   = tb_addr;
    assign if0.req_addr   = tb_addr;
    assign if2.req_wdata  = tb_wdata;
    assign if0.req_wdata  = tb_wdata;
    assign if2.req_be     = tb_be;
    assign if0.req_be     = tb_be;

    assign obs_req_ready  = sel ? if0.req_ready  : if2.req_ready;
    assign obs_resp_valid = sel ? if0.resp_valid : if2.resp_valid;
    assign obs_resp_err   = sel ? if0.resp_err   : if2.resp_err;
    assign obs_resp_rdata = sel ? if0.resp_rdata : if2.resp_rdata;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (2),
        .BASE_ADDR   (BASE)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (0),
        .BASE_ADDR   (BASE)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic void model_txn(input bit s, input logic wr, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be,
                                      output logic [31:0] rd, output logic err);
        longint off;
        int w;
        off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
        err = (addr[1:0] != 2'b00) || (off < 0) || (off >= longint'(4 * DEPTH));
        rd  = 32'h0;
        if (!err) begin
            w = int'(off / 4);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model_mem[s][w][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                rd = model_mem[s][w];
            end
        end
    endfunction

    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int hold, input bit churn);
        logic [31:0] exp_rd;
        logic exp_err;
        int exp_lat;
        int n;
        int lat;
        exp_lat = sel ? 1 : 3;
        model_txn(sel, wr, addr, wdata, be, exp_rd, exp_err);
        @(negedge clk);
        n = 0;
        while (obs_req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (obs_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: req_ready=%b required 1", name, obs_req_ready);
            return;
        end
        tb_req_valid = 1'b1;
        tb_write     = wr;
        tb_addr      = addr;
        tb_wdata     = wdata;
        tb_be        = be;
        @(posedge clk);
        @(negedge clk);
        tb_req_valid = churn ? 1'($urandom_range(0, 1)) : 1'b0;
        if (churn) begin
            tb_addr  = $urandom;
            tb_wdata = $urandom;
            tb_be    = 4'($urandom);
            tb_write = 1'($urandom);
        end
        checks++;
        if (obs_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_ready: req_ready=%b required 0", name, obs_req_ready);
        end
        lat = 1;
        while (obs_resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (churn) tb_addr = $urandom;
        end
        tb_req_valid = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
            if (lat >= 40) return;
        end
        checks++;
        if (obs_resp_rdata !== exp_rd || obs_resp_err !== exp_err) begin
            errors++;
            $display("FAIL %s response: rdata=%h err=%b required rdata=%h err=%b",
                     name, obs_resp_rdata, obs_resp_err, exp_rd, exp_err);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (obs_resp_valid !== 1'b1 || obs_resp_rdata !== exp_rd ||
                obs_resp_err !== exp_err || obs_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold[%0d]: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                         name, i, obs_resp_valid, obs_resp_rdata, obs_resp_err, obs_req_ready,
                         exp_rd, exp_err);
            end
        end
        tb_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_resp_ready = 1'b0;
        checks++;
        if (obs_resp_valid !== 1'b0 || obs_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: valid=%b ready=%b required 0 1",
                     name, obs_resp_valid, obs_req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if2.req_ready !== 1'b1 || if2.resp_valid !== 1'b0 ||
            if2.resp_rdata !== 32'h0 || if2.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_lat2: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     if2.req_ready, if2.resp_valid, if2.resp_rdata, if2.resp_err);
        end
        checks++;
        if (if0.req_ready !== 1'b1 || if0.resp_valid !== 1'b0 ||
            if0.resp_rdata !== 32'h0 || if0.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_lat0: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     if0.req_ready, if0.resp_valid, if0.resp_rdata, if0.resp_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_init();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int w = 0; w < DEPTH; w++) begin
                run_txn("init", 1'b1, BASE + 32'(w * 4), 32'h0, 4'hF, 0, 1'b0);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_store_load();
        sel = 1'b0;
        run_txn("store_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        run_txn("load_10", 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        run_txn("partial_store", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 1'b0);
        run_txn("partial_load", 1'b0, 32'h10, 32'h0, 4'hF, 1, 1'b0);
        run_txn("be0_store", 1'b1, 32'h10, 32'h5555_5555, 4'b0000, 0, 1'b0);
        run_txn("be0_load", 1'b0, 32'h10, 32'h0, 4'b0110, 0, 1'b0);
    endtask

    task automatic test_errors();
        sel = 1'b0;
        run_txn("load_misaligned", 1'b0, 32'h13, 32'h0, 4'hF, 0, 1'b0);
        run_txn("store_oor", 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        run_txn("load_0_after_oor", 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0);
        run_txn("store_misaligned", 1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        run_txn("load_0_after_mis", 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0);
        run_txn("load_last", 1'b0, 32'h3FC, 32'h0, 4'hF, 0, 1'b0);
        run_txn("load_high", 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        run_txn("bp_load", 1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1);
        run_txn("bp_store", 1'b1, 32'h14, 32'h0BAD_CAFE, 4'hF, 5, 1'b1);
        run_txn("bp_err", 1'b0, 32'h401, 32'h0, 4'hF, 5, 1'b1);
    endtask

    task automatic test_latency0();
        sel = 1'b1;
        run_txn("l0_store", 1'b1, 32'h40, 32'hA5A5_1234, 4'hF, 0, 1'b1);
        run_txn("l0_load", 1'b0, 32'h40, 32'h0, 4'hF, 2, 1'b1);
        run_txn("l0_partial", 1'b1, 32'h40, 32'hFF00_0000, 4'b1000, 0, 1'b1);
        run_txn("l0_reload", 1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b1);
        run_txn("l0_err", 1'b0, 32'h41, 32'h0, 4'hF, 3, 1'b1);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        sel = 1'b0;
        @(negedge clk);
        tb_req_valid = 1'b1;
        tb_write     = 1'b1;
        tb_addr      = 32'h20;
        tb_wdata     = 32'h1234_5678;
        tb_be        = 4'hF;
        @(posedge clk);
        @(negedge clk);
        tb_req_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_resp_valid !== 1'b0 || obs_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wait_state: valid=%b ready=%b required 0 1",
                     obs_resp_valid, obs_req_ready);
        end
        reset = 1'b0;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (obs_resp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_wait_noresp: resp_valid rose=1 required 0");
        end
        run_txn("reset_wait_load", 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0);
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] d_rd;
        logic d_err;
        int n;
        sel = 1'b0;
        model_txn(1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, 4'hF, d_rd, d_err);
        @(negedge clk);
        tb_req_valid = 1'b1;
        tb_write     = 1'b1;
        tb_addr      = 32'h24;
        tb_wdata     = 32'hCAFE_F00D;
        tb_be        = 4'hF;
        @(posedge clk);
        @(negedge clk);
        tb_req_valid = 1'b0;
        n = 0;
        while (obs_resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_resp_valid !== 1'b0 || obs_req_ready !== 1'b1 || obs_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_state: valid=%b ready=%b err=%b required 0 1 0",
                     obs_resp_valid, obs_req_ready, obs_resp_err);
        end
        reset = 1'b0;
        run_txn("reset_resp_load", 1'b0, 32'h24, 32'h0, 4'hF, 0, 1'b0);
    endtask

    task automatic test_reset_held();
        bit bad;
        sel = 1'b0;
        @(negedge clk);
        reset        = 1'b1;
        tb_req_valid = 1'b1;
        tb_write     = 1'b1;
        tb_addr      = 32'h28;
        tb_wdata     = 32'hFFFF_FFFF;
        tb_be        = 4'hF;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (obs_req_ready !== 1'b1 || obs_resp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_held: ready=%b valid=%b required 1 0",
                     obs_req_ready, obs_resp_valid);
        end
        reset        = 1'b0;
        tb_req_valid = 1'b0;
        run_txn("reset_held_load", 1'b0, 32'h28, 32'h0, 4'hF, 0, 1'b0);
    endtask

    task automatic test_random();
        int r;
        logic [31:0] addr;
        for (int i = 0; i < 110; i++) begin
            sel = (i >= 80);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                addr = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            end else if (r == 1) begin
                addr = 32'h400 + (32'($urandom_range(0, 100000)) << 2);
            end else begin
                addr = 32'($urandom_range(0, 15)) << 2;
            end
            run_txn("random", 1'($urandom), addr, $urandom, 4'($urandom),
                    $urandom_range(0, 3), 1'($urandom));
        end
        sel = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        sel           = 1'b0;
        reset         = 1'b1;
        tb_req_valid  = 1'b0;
        tb_write      = 1'b0;
        tb_addr       = 32'h0;
        tb_wdata      = 32'h0;
        tb_be         = 4'h0;
        tb_resp_ready = 1'b0;
        test_reset();
        test_init();
        test_store_load();
        test_errors();
        test_backpressure();
        test_latency0();
        test_reset_mid_wait();
        test_reset_in_resp();
        test_reset_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
